// File: rtl/ex_shift_sequencer.sv
// ex_shift_sequencer: multi-cycle EX-stage operand-2 engine.
// Builds val2 from one of three sources:
//   - val_rm shifted by an immediate amount
//   - an 8-bit immediate rotated right by an even amount
//   - a load/store offset passed straight through
// At most STEP bits of shift/rotate are applied per clock, which keeps a full
// 32-bit barrel shifter off the EX critical path. busy is meant to be OR-ed into
// the pipeline freeze.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          request; accepted only when ready=1
//   flush          synchronous abort of an in-flight operation; in IDLE it drops start
//   imm            1: rotated immediate, 0: shifted register
//   shift_operand  ARM shifter operand field
//   val_rm         Rm register value
//   mem_R_en       load command (offset pass-through)
//   mem_W_en       store command (offset pass-through)
//   ready          combinational, 1 in IDLE
//   busy           registered, 1 while in SHIFT
//   valid          one-cycle pulse when val2 holds a new result
//   val2           result, held until the next result or reset
module ex_shift_sequencer #(
    parameter int unsigned STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    input  logic        mem_R_en,
    input  logic        mem_W_en,
    output logic        ready,
    output logic        busy,
    output logic        valid,
    output logic [31:0] val2
);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    state_t      state;
    logic [31:0] data_q;
    logic [1:0]  op_q;
    logic [5:0]  rem_q;

    // Operand selection from the live inputs; used only at the acceptance edge.
    logic [31:0] sel_data;
    logic [1:0]  sel_op;
    logic [5:0]  sel_amt;

    always_comb begin
        sel_data = val_rm;
        sel_op   = shift_operand[6:5];
        // Register-specified shifts are not supported here: treat as amount 0.
        sel_amt  = shift_operand[4] ? 6'd0 : {1'b0, shift_operand[11:7]};
        if (mem_R_en || mem_W_en) begin
            sel_data = {20'd0, shift_operand};
            sel_op   = 2'b00;
            sel_amt  = 6'd0;
        end else if (imm) begin
            sel_data = {24'd0, shift_operand[7:0]};
            sel_op   = 2'b11;
            sel_amt  = {1'b0, shift_operand[11:8], 1'b0};
        end
    end

    // One step of at most STEP bits. In IDLE the step works on the freshly
    // selected operand so a short operation completes at the acceptance edge.
    logic [31:0] cur_data;
    logic [1:0]  cur_op;
    logic [5:0]  cur_rem;
    logic [5:0]  step_amt;
    logic        last_step;
    logic [31:0] step_res;

    always_comb begin
        cur_data  = (state == IDLE) ? sel_data : data_q;
        cur_op    = (state == IDLE) ? sel_op   : op_q;
        cur_rem   = (state == IDLE) ? sel_amt  : rem_q;
        step_amt  = (cur_rem > STEP_AMT) ? STEP_AMT : cur_rem;
        last_step = (cur_rem <= STEP_AMT);
        case (cur_op)
            2'b00:   step_res = cur_data << step_amt;
            2'b01:   step_res = cur_data >> step_amt;
            2'b10:   step_res = 32'($signed(cur_data) >>> step_amt);
            // A left shift by 32 yields 0, so step_amt=0 is a clean pass-through.
            default: step_res = (cur_data >> step_amt) | (cur_data << (6'd32 - step_amt));
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= 32'd0;
            op_q   <= 2'b00;
            rem_q  <= 6'd0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            val2   <= 32'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // flush has priority over start: the request is dropped.
                    if (start && !flush) begin
                        if (last_step) begin
                            val2  <= step_res;
                            valid <= 1'b1;
                        end else begin
                            data_q <= step_res;
                            op_q   <= cur_op;
                            rem_q  <= cur_rem - step_amt;
                            busy   <= 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last_step) begin
                        val2  <= step_res;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        data_q <= step_res;
                        rem_q  <= cur_rem - step_amt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_shift_sequencer.sv
// Bench for ex_shift_sequencer: two instances (STEP=8 and STEP=1) share one
// stimulus stream and are checked every cycle against a transaction-level model.
// The model computes the whole shift in one go and tracks a latency countdown.
module tb_ex_shift_sequencer;

    localparam int STEP_A = 8;
    localparam int STEP_B = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        imm = 1'b0;
    logic [11:0] shift_operand = 12'd0;
    logic [31:0] val_rm = 32'd0;
    logic        mem_R_en = 1'b0;
    logic        mem_W_en = 1'b0;

    logic        ready_a, busy_a, valid_a;
    logic [31:0] val2_a;
    logic        ready_b, busy_b, valid_b;
    logic [31:0] val2_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_shift_sequencer #(.STEP(STEP_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .imm(imm),
        .shift_operand(shift_operand), .val_rm(val_rm),
        .mem_R_en(mem_R_en), .mem_W_en(mem_W_en),
        .ready(ready_a), .busy(busy_a), .valid(valid_a), .val2(val2_a)
    );

    ex_shift_sequencer #(.STEP(STEP_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .imm(imm),
        .shift_operand(shift_operand), .val_rm(val_rm),
        .mem_R_en(mem_R_en), .mem_W_en(mem_W_en),
        .ready(ready_b), .busy(busy_b), .valid(valid_b), .val2(val2_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_left  [2] = '{0, 0};  // clock edges still needed to finish
    logic [31:0] m_res   [2] = '{32'd0, 32'd0};
    logic [31:0] m_val2  [2] = '{32'd0, 32'd0};
    logic        m_valid [2] = '{1'b0, 1'b0};

    function automatic logic [31:0] full_shift(input logic [31:0] d, input int op, input int amt);
        logic [63:0] dd;
        case (op)
            0: return d << amt;
            1: return d >> amt;
            2: return 32'($signed(d) >>> amt);
            default: begin
                dd = {d, d} >> amt;
                return dd[31:0];
            end
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [11:0] so;
        int op, amt, n, st;
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                st = (k == 0) ? STEP_A : STEP_B;
                if (rst) begin
                    m_left[k] = 0; m_val2[k] = 32'd0; m_valid[k] = 1'b0; m_res[k] = 32'd0;
                end else begin
                    m_valid[k] = 1'b0;
                    if (m_left[k] > 0) begin
                        if (flush) m_left[k] = 0;
                        else begin
                            m_left[k]--;
                            if (m_left[k] == 0) begin
                                m_val2[k] = m_res[k];
                                m_valid[k] = 1'b1;
                            end
                        end
                    end else if (start && !flush) begin
                        so = shift_operand;
                        if (mem_R_en || mem_W_en) begin
                            d = {20'd0, so}; op = 0; amt = 0;
                        end else if (imm) begin
                            d = {24'd0, so[7:0]}; op = 3; amt = 2 * int'(so[11:8]);
                        end else begin
                            d = val_rm; op = int'(so[6:5]);
                            amt = so[4] ? 0 : int'(so[11:7]);
                        end
                        n = (amt == 0) ? 1 : (amt + st - 1) / st;
                        if (n == 1) begin
                            m_val2[k] = full_shift(d, op, amt);
                            m_valid[k] = 1'b1;
                        end else begin
                            m_res[k] = full_shift(d, op, amt);
                            m_left[k] = n - 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("a.ready", 32'(ready_a), 32'(m_left[0] == 0));
            check("a.busy",  32'(busy_a),  32'(m_left[0] != 0));
            check("a.valid", 32'(valid_a), 32'(m_valid[0]));
            check("a.val2",  val2_a, m_val2[0]);
            check("b.ready", 32'(ready_b), 32'(m_left[1] == 0));
            check("b.busy",  32'(busy_b),  32'(m_left[1] != 0));
            check("b.valid", 32'(valid_b), 32'(m_valid[1]));
            check("b.val2",  val2_b, m_val2[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            start = 1'b0; flush = 1'b0; mem_R_en = 1'b0; mem_W_en = 1'b0;
        end
    endtask

    // Present a request for exactly one acceptance edge; returns just after it.
    task automatic launch(input logic i_imm, input logic i_mr, input logic [11:0] so,
                          input logic [31:0] rm);
        @(negedge clk);
        #1;
        start = 1'b1; imm = i_imm; mem_R_en = i_mr; mem_W_en = 1'b0;
        shift_operand = so; val_rm = rm;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst.val2", val2_a, 32'd0);
        check("rst.ready", 32'(ready_a), 32'd1);
        check("rst.busy", 32'(busy_a), 32'd0);
        #1 rst = 1'b0;
        idle(2);

        // 1: imm ROR 8 of 0xFF
        launch(1'b1, 1'b0, 12'h4FF, 32'd0);
        @(negedge clk);
        check("t1.valid", 32'(valid_a), 32'd1);
        check("t1.val2", val2_a, 32'hFF000000);
        check("t1.busy", 32'(busy_a), 32'd0);
        idle(12);

        // 2: ASR #20 of 0x80000000
        launch(1'b0, 1'b0, 12'hA40, 32'h80000000);
        @(negedge clk);
        check("t2.busy1", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("t2.busy2", 32'(busy_a), 32'd1);
        check("t2.valid2", 32'(valid_a), 32'd0);
        @(negedge clk);
        check("t2.valid3", 32'(valid_a), 32'd1);
        check("t2.val2", val2_a, 32'hFFFFF800);
        idle(24);

        // 3: load offset, imm ignored
        launch(1'b1, 1'b1, 12'hFFC, 32'hDEADBEEF);
        @(negedge clk);
        check("t3.valid", 32'(valid_a), 32'd1);
        check("t3.val2", val2_a, 32'h00000FFC);
        idle(4);

        // 4: ROR #31 of 1, with start pulses while busy
        launch(1'b0, 1'b0, 12'hFE0, 32'h00000001);
        @(negedge clk);
        #1;
        start = 1'b1; imm = 1'b1; shift_operand = 12'h000; val_rm = 32'h55555555;
        @(negedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t4.valid3", 32'(valid_a), 32'd0);
        @(negedge clk);
        check("t4.valid4", 32'(valid_a), 32'd1);
        check("t4.val2", val2_a, 32'h00000002);
        idle(40);
        check("t4.b.val2", val2_b, 32'h00000002);

        // 5: flush LSL #16 in cycle 1
        launch(1'b0, 1'b0, 12'h800, 32'h0000ABCD);
        @(negedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("t5.valid", 32'(valid_a), 32'd0);
        check("t5.val2", val2_a, 32'h00000002);
        check("t5.ready", 32'(ready_a), 32'd1);
        #1 flush = 1'b0;
        idle(3);
        // 5b: reset mid-operation
        launch(1'b0, 1'b0, 12'h800, 32'h0000ABCD);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5r.val2", val2_a, 32'd0);
        check("t5r.ready", 32'(ready_a), 32'd1);
        check("t5r.b.busy", 32'(busy_b), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle(2);

        // 6: STEP=1 instance, LSR #5 of 0xF0
        launch(1'b0, 1'b0, 12'h2A0, 32'h000000F0);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        check("t6.b.valid4", 32'(valid_b), 32'd0);
        @(negedge clk);
        check("t6.b.valid5", 32'(valid_b), 32'd1);
        check("t6.b.val2", val2_b, 32'h00000007);
        idle(2);
        // 6b: LSL #0 pass-through
        launch(1'b0, 1'b0, 12'h000, 32'h12345678);
        @(negedge clk);
        check("t6p.b.valid", 32'(valid_b), 32'd1);
        check("t6p.b.val2", val2_b, 32'h12345678);
        idle(2);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            start         = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            imm           = 1'($urandom_range(0, 1));
            mem_R_en      = ($urandom_range(0, 7) == 0);
            mem_W_en      = ($urandom_range(0, 7) == 0);
            shift_operand = 12'($urandom);
            val_rm        = $urandom;
        end
        #1 rst = 1'b0;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
